// File: rtl/vga_pkg.sv
// rtl/vga_pkg.sv - shared constants and state type for the text-mode VRAM writer
package vga_pkg;

  localparam int VRAM_AW = 11;

  localparam logic [7:0] CH_BS    = 8'h08;
  localparam logic [7:0] CH_LF    = 8'h0A;
  localparam logic [7:0] CH_FF    = 8'h0C;
  localparam logic [7:0] CH_CR    = 8'h0D;
  localparam logic [7:0] CH_BLANK = 8'h20;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    CLR_ROW = 2'd1,
    CLR_ALL = 2'd2
  } state_t;

endpackage

// File: rtl/vram_text_writer.sv
// rtl/vram_text_writer.sv - byte stream to VRAM writes with cursor, control codes and rolling row clears
module vram_text_writer
  import vga_pkg::*;
#(
  parameter int         COLS  = 40,
  parameter int         ROWS  = 30,
  parameter logic [7:0] BLANK = CH_BLANK
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                in_valid,
  input  logic [7:0]          in_data,
  output logic                in_ready,
  output logic                vram_we,
  output logic [VRAM_AW-1:0]  vram_waddr,
  output logic [7:0]          vram_wdata,
  output logic [5:0]          cursor_x,
  output logic [4:0]          cursor_y,
  output logic                busy
);

  localparam logic [5:0] LAST_X = 6'(COLS - 1);
  localparam logic [4:0] LAST_Y = 5'(ROWS - 1);

  state_t               state, state_n;
  logic [VRAM_AW-1:0]   cnt, cnt_n;
  logic [5:0]           x_n;
  logic [4:0]           y_n;
  logic                 we_n;
  logic [VRAM_AW-1:0]   waddr_n;
  logic [7:0]           wdata_n;
  logic                 newline;
  logic                 accept;

  assign accept = in_valid && in_ready;

  always_comb begin
    state_n = state;
    cnt_n   = cnt + 11'd1;
    x_n     = cursor_x;
    y_n     = cursor_y;
    we_n    = 1'b0;
    waddr_n = vram_waddr;
    wdata_n = vram_wdata;
    newline = 1'b0;
    case (state)
      CLR_ALL: begin
        we_n    = 1'b1;
        waddr_n = cnt;
        wdata_n = BLANK;
        if (cnt == 11'h7FF) state_n = IDLE;
      end
      CLR_ROW: begin
        we_n    = 1'b1;
        waddr_n = {cursor_y, cnt[5:0]};
        wdata_n = BLANK;
        if (cnt[5:0] == 6'h3F) state_n = IDLE;
      end
      default: begin
        cnt_n = '0;
        if (accept) begin
          if (in_data >= 8'h20 && in_data <= 8'h7E) begin
            we_n    = 1'b1;
            waddr_n = {cursor_y, cursor_x};
            wdata_n = in_data;
            if (cursor_x == LAST_X) begin
              x_n     = '0;
              newline = 1'b1;
            end else begin
              x_n = cursor_x + 6'd1;
            end
          end else begin
            case (in_data)
              CH_LF: begin
                x_n     = '0;
                newline = 1'b1;
              end
              CH_CR: x_n = '0;
              CH_BS: if (cursor_x != 6'd0) x_n = cursor_x - 6'd1;
              CH_FF: begin
                x_n     = '0;
                y_n     = '0;
                state_n = CLR_ALL;
              end
              default: ;
            endcase
          end
          // Entering a row always blanks it, giving the rolling-terminal look.
          if (newline) begin
            y_n     = (cursor_y == LAST_Y) ? 5'd0 : cursor_y + 5'd1;
            state_n = CLR_ROW;
          end
        end
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= CLR_ALL;
      cnt        <= '0;
      cursor_x   <= '0;
      cursor_y   <= '0;
      vram_we    <= 1'b0;
      vram_waddr <= '0;
      vram_wdata <= BLANK;
      in_ready   <= 1'b0;
      busy       <= 1'b1;
    end else begin
      state      <= state_n;
      cnt        <= cnt_n;
      cursor_x   <= x_n;
      cursor_y   <= y_n;
      vram_we    <= we_n;
      vram_waddr <= waddr_n;
      vram_wdata <= wdata_n;
      in_ready   <= (state_n == IDLE);
      busy       <= (state_n != IDLE);
    end
  end

endmodule

// File: tb/tb_vram_text_writer.sv
// tb/tb_vram_text_writer.sv - scoreboard bench for vram_text_writer
module tb_vram_text_writer;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic [7:0]  in_data;
  logic        in_ready;
  logic        vram_we;
  logic [10:0] vram_waddr;
  logic [7:0]  vram_wdata;
  logic [5:0]  cursor_x;
  logic [4:0]  cursor_y;
  logic        busy;

  int n_vec = 0;
  int n_err = 0;

  logic [18:0] sb_q[$];
  logic [5:0]  mx;
  logic [4:0]  my;

  vram_text_writer dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid),
    .in_data    (in_data),
    .in_ready   (in_ready),
    .vram_we    (vram_we),
    .vram_waddr (vram_waddr),
    .vram_wdata (vram_wdata),
    .cursor_x   (cursor_x),
    .cursor_y   (cursor_y),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (rst_n === 1'b1 && vram_we === 1'b1) begin
      if (sb_q.size() == 0) begin
        check("unexpected_write", {21'd0, vram_waddr}, 32'hFFFF_FFFF);
      end else begin
        logic [18:0] e;
        e = sb_q.pop_front();
        check("waddr", {21'd0, vram_waddr}, {21'd0, e[18:8]});
        check("wdata", {24'd0, vram_wdata}, {24'd0, e[7:0]});
      end
    end
  end

  task automatic push_clear_all();
    for (int a = 0; a < 2048; a++) sb_q.push_back({a[10:0], 8'h20});
  endtask

  task automatic model_newline();
    my = (my == 5'd29) ? 5'd0 : my + 5'd1;
    for (int c = 0; c < 64; c++) sb_q.push_back({my, c[5:0], 8'h20});
  endtask

  task automatic model_byte(input logic [7:0] b);
    if (b >= 8'h20 && b <= 8'h7E) begin
      sb_q.push_back({my, mx, b});
      if (mx == 6'd39) begin
        mx = 6'd0;
        model_newline();
      end else begin
        mx = mx + 6'd1;
      end
    end else if (b == 8'h0A) begin
      mx = 6'd0;
      model_newline();
    end else if (b == 8'h0D) begin
      mx = 6'd0;
    end else if (b == 8'h08) begin
      if (mx != 6'd0) mx = mx - 6'd1;
    end else if (b == 8'h0C) begin
      mx = 6'd0;
      my = 5'd0;
      push_clear_all();
    end
  endtask

  task automatic wait_ready();
    int t;
    t = 0;
    @(negedge clk);
    while (!in_ready && t < 5000) begin
      @(negedge clk);
      t++;
    end
    if (!in_ready) check("ready_timeout", {31'd0, in_ready}, 32'd1);
  endtask

  task automatic send(input logic [7:0] b);
    wait_ready();
    model_byte(b);
    in_valid = 1'b1;
    in_data  = b;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    in_data  = 8'h00;
  endtask

  task automatic count_clear(output int n);
    n = 0;
    for (int i = 0; i < 5000; i++) begin
      @(negedge clk);
      if (!busy) break;
      check("ready_during_clear", {31'd0, in_ready}, 32'd0);
      n++;
    end
  endtask

  task automatic check_cursor(input string tag);
    wait_ready();
    check({tag, "_x"}, {26'd0, cursor_x}, {26'd0, mx});
    check({tag, "_y"}, {27'd0, cursor_y}, {27'd0, my});
  endtask

  initial begin
    int n;
    rst_n    = 1'b0;
    in_valid = 1'b0;
    in_data  = 8'h00;
    mx       = 6'd0;
    my       = 5'd0;

    // reset state
    @(negedge clk);
    check("rst_we",     {31'd0, vram_we},    32'd0);
    check("rst_waddr",  {21'd0, vram_waddr}, 32'd0);
    check("rst_wdata",  {24'd0, vram_wdata}, 32'h20);
    check("rst_busy",   {31'd0, busy},       32'd1);
    check("rst_ready",  {31'd0, in_ready},   32'd0);
    check("rst_cx",     {26'd0, cursor_x},   32'd0);
    check("rst_cy",     {27'd0, cursor_y},   32'd0);
    push_clear_all();
    @(posedge clk);
    #1 rst_n = 1'b1;
    count_clear(n);
    check("busy_cycles", n, 32'd2048);
    check_cursor("after_reset");

    // "AB"
    send(8'h41);
    send(8'h42);
    check_cursor("ab");

    // right-edge wrap from (39,3)
    send(8'h0D);
    while (my != 5'd3) send(8'h0A);
    while (mx != 6'd39) send(8'h2E);
    check_cursor("at_39_3");
    send(8'h5A);
    count_clear(n);
    check("row_clear_cycles", n, 32'd64);
    check_cursor("wrap");

    // bottom-row wrap with LF
    while (my != 5'd29) send(8'h0A);
    send(8'h0A);
    check_cursor("lf_bottom");
    send(8'h51);
    check_cursor("q");

    // BS / CR / ignored codes
    send(8'h0D);
    for (int i = 0; i < 5; i++) send(8'h61);
    send(8'h08);
    send(8'h08);
    send(8'h78);
    send(8'h0D);
    send(8'h07);
    send(8'h80);
    send(8'h08);
    check_cursor("bs_cr");

    // form feed
    send(8'h31);
    send(8'h0C);
    count_clear(n);
    check("ff_clear_cycles", n, 32'd2048);
    check_cursor("ff");

    // reset in the middle of a row clear, with a byte pending
    send(8'h0A);
    repeat (10) @(negedge clk);
    in_valid = 1'b1;
    in_data  = 8'h4B;
    @(negedge clk);
    #1 rst_n = 1'b0;
    #1;
    check("midrst_we",    {31'd0, vram_we},    32'd0);
    check("midrst_waddr", {21'd0, vram_waddr}, 32'd0);
    check("midrst_busy",  {31'd0, busy},       32'd1);
    check("midrst_ready", {31'd0, in_ready},   32'd0);
    check("midrst_cy",    {27'd0, cursor_y},   32'd0);
    sb_q.delete();
    mx = 6'd0;
    my = 5'd0;
    push_clear_all();
    @(posedge clk);
    #1 rst_n = 1'b1;
    count_clear(n);
    check("midrst_clear_cycles", n, 32'd2048);
    model_byte(8'h4B);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    check_cursor("after_midrst");

    repeat (4) @(negedge clk);
    check("sb_empty", sb_q.size(), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/vram_text_writer.md
Name: vram_text_writer

Overview:
- Writer side of the character display's VRAM: turns a byte stream of ASCII text and control codes into single-port writes on the sync SRAM.
- The display engine reads the same SRAM using address {row[4:0], col[5:0]}.
- Keeps a cursor, handles CR/LF/BS/FF, wraps at the right edge, and wraps the bottom row back to row 0.
- Clears each newly entered row so the console behaves as a rolling terminal.

Parameters:
- COLS, 40, visible columns; cursor_x range 0..COLS-1; legal 1..64.
- ROWS, 30, visible rows; cursor_y range 0..ROWS-1; legal 1..32.
- BLANK, 8'h20, fill byte written by row and screen clears.

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- in_valid  in  1  in_data holds a byte to consume
- in_data  in  8  ASCII byte or control code
- in_ready  out  1  block can accept a byte this cycle
- vram_we  out  1  write strobe to VRAM write port
- vram_waddr  out  11  write address {row[4:0], col[5:0]}
- vram_wdata  out  8  write data
- cursor_x  out  6  current column
- cursor_y  out  5  current row
- busy  out  1  clear sequence in progress

Behaviour:
- Reset (rst_n low, asynchronous):
  - cursor_x=0, cursor_y=0, vram_we=0, vram_waddr=0, vram_wdata=BLANK.
  - State=CLR_ALL with clear counter=0, so busy=1 and in_ready=0 in the first cycle after rst_n deasserts.
- All outputs are registered. in_ready = (state==IDLE).
- Handshake: a byte is accepted when in_valid && in_ready. At most one byte per cycle. in_data is sampled only on acceptance.
- States:
  - IDLE: accepts bytes.
  - CLR_ROW: writes BLANK to {cursor_y, 0..63}, 64 cycles, counter increments by 1 each cycle. Returns to IDLE after col 63 is written.
  - CLR_ALL: writes BLANK to addresses 0..2047, 2048 cycles. Returns to IDLE after 2047 is written. Cursor is held at 0,0.
- Byte handling in IDLE:
  - 0x20..0x7E, printable:
    - Next cycle: vram_we=1, vram_waddr={cursor_y,cursor_x}, vram_wdata=in_data. Write latency is 1 cycle.
    - If cursor_x==COLS-1, perform NEWLINE. Otherwise cursor_x+1.
  - 0x0A, LF: cursor_x=0, then NEWLINE. No character write.
  - 0x0D, CR: cursor_x=0.
  - 0x08, BS: if cursor_x>0, cursor_x-1; at column 0 there is no change. No write.
  - 0x0C, FF: cursor_x=0, cursor_y=0, enter CLR_ALL.
  - All other bytes (0x00..0x1F not listed above, 0x7F..0xFF) are consumed and ignored. No write, no cursor change.
- NEWLINE:
  - cursor_y = (cursor_y==ROWS-1) ? 0 : cursor_y+1.
  - Enter CLR_ROW for the new cursor_y.
  - The first clear write appears the cycle after the printable write. On a wrap-triggered newline, the printed character is written first, then the 64 clear writes.
- vram_we is 0 in IDLE cycles with no accepted printable byte.
- Columns COLS..63 are cleared but never written with characters.
- Reset asserted mid-clear aborts the clear and restarts CLR_ALL from address 0. Partial writes are not an error.
- in_valid held high during CLR_* is not consumed. in_data may change freely while in_ready=0.

Decomposition:
- Shared package vga_pkg holds:
  - constants CH_BS=8'h08, CH_LF=8'h0A, CH_FF=8'h0C, CH_CR=8'h0D, CH_BLANK=8'h20
  - the state enum {IDLE, CLR_ROW, CLR_ALL}
  - VRAM_AW=11
- No sub-module: the clear sequencer is one 11-bit counter inside the FSM.

Test Plan:
- Reset, then idle: busy=1 for exactly 2048 cycles, vram_waddr steps 0..2047 with vram_wdata=0x20; then in_ready=1, cursor 0,0.
- Send "AB": writes {0,0}=0x41 and {0,1}=0x42, each one cycle after acceptance; cursor_x=2.
- At cursor (39,3), send 'Z': write addr {3,39}=0x5A; cursor becomes (0,4); 64 BLANK writes to 4*64..4*64+63; in_ready=0 during those cycles.
- At cursor_y=29, send LF: cursor (0,0), clear writes to addresses 0..63; then 'Q' writes addr 0.
- At x=5 send BS,BS,'x',CR,0x07,0x80: one write {y,3}=0x78; final cursor_x=0; no writes for 0x07 or 0x80.
- Assert rst_n low in the middle of a row clear with in_valid held high: outputs reset immediately; CLR_ALL restarts from 0; no byte is consumed until busy drops.
